// File: rtl/i2s_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_frame_controller
//  Description : Master-side I2S sequencer. Divides clk into bck/lrck, holds
//                one stereo pair from a valid/ready source and swaps it into
//                datl/datr once per frame, flagging and counting underruns.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_frame_controller #(
  parameter int CLK_DIV          = 2,
  parameter int WIDTH            = 16,
  parameter int MUTE_ON_UNDERRUN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             bck,
  output logic             lrck,
  output logic [WIDTH-1:0] datl,
  output logic [WIDTH-1:0] datr,
  output logic             frame_start,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_BIT_W = $clog2(2 * WIDTH);
  localparam logic [c_DIV_W-1:0] c_DIV_MAX  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(2 * WIDTH - 1);
  localparam logic [c_BIT_W-1:0] c_HALF     = c_BIT_W'(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [c_DIV_W-1:0] div_cnt_q;
  logic [c_BIT_W-1:0] bit_cnt_q;
  logic               bck_q;
  logic               lrck_q;
  logic [WIDTH-1:0]   datl_q;
  logic [WIDTH-1:0]   datr_q;
  logic [WIDTH-1:0]   buf_l_q;
  logic [WIDTH-1:0]   buf_r_q;
  logic               buf_empty_q;
  logic               frame_start_q;
  logic               underrun_q;
  logic [7:0]         underrun_cnt_q;

  logic               w_accept;
  logic [c_BIT_W-1:0] w_bit_next;

  // Handshake qualifier and the bit counter value after the next bck fall
  assign w_accept   = in_valid & buf_empty_q;
  assign w_bit_next = (bit_cnt_q == c_BIT_LAST) ? '0 : bit_cnt_q + 1'b1;

  // Clock division, frame sequencing, buffer handshake and load point
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      bck_q          <= 1'b0;
      lrck_q         <= 1'b0;
      datl_q         <= '0;
      datr_q         <= '0;
      buf_l_q        <= '0;
      buf_r_q        <= '0;
      buf_empty_q    <= 1'b1;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;

      // An accept while empty is independent of the load point: a pair
      // arriving on the load clk still lands in the buffer for next frame.
      if (w_accept) begin
        buf_l_q     <= in_left;
        buf_r_q     <= in_right;
        buf_empty_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          bck_q     <= 1'b0;
          lrck_q    <= 1'b0;
          div_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (en) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            state_q   <= S_IDLE;
            bck_q     <= 1'b0;
            lrck_q    <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
          end else if (div_cnt_q == c_DIV_MAX) begin
            div_cnt_q <= '0;
            bck_q     <= ~bck_q;
            if (!bck_q) begin
              // bck rising: the last bit's rise is the frame load point
              if (bit_cnt_q == c_BIT_LAST) begin
                frame_start_q <= 1'b1;
                if (!buf_empty_q) begin
                  datl_q      <= buf_l_q;
                  datr_q      <= buf_r_q;
                  buf_empty_q <= 1'b1;
                end else begin
                  underrun_q <= 1'b1;
                  if (underrun_cnt_q != 8'hFF) begin
                    underrun_cnt_q <= underrun_cnt_q + 8'd1;
                  end
                  if (MUTE_ON_UNDERRUN != 0) begin
                    datl_q <= '0;
                    datr_q <= '0;
                  end
                end
              end
            end else begin
              // bck falling: advance bit position, word select follows
              bit_cnt_q <= w_bit_next;
              lrck_q    <= (w_bit_next >= c_HALF);
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready     = buf_empty_q;
  assign bck          = bck_q;
  assign lrck         = lrck_q;
  assign datl         = datl_q;
  assign datr         = datr_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_frame_controller
//  Description : Scoreboard bench for i2s_frame_controller. A timeline model
//                predicts clocks, buffer state and load-point events; a
//                monitor compares a muting and a holding instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_frame_controller;

  localparam int CD    = 2;
  localparam int W     = 16;
  localparam int P     = 2 * CD * 2 * W;            // clk cycles per frame
  localparam int LOADR = 2 * CD * (2 * W - 1) + CD; // load edge offset in frame

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, in_valid;
  logic [15:0] in_left, in_right;

  logic        rdy_m, bck_m, lrck_m, fs_m, ur_m;
  logic [15:0] dl_m, dr_m;
  logic [7:0]  cnt_m;
  logic        rdy_h, bck_h, lrck_h, fs_h, ur_h;
  logic [15:0] dl_h, dr_h;
  logic [7:0]  cnt_h;

  i2s_frame_controller #(.CLK_DIV(CD), .WIDTH(W), .MUTE_ON_UNDERRUN(1)) u_mute (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(rdy_m),
    .in_left(in_left), .in_right(in_right), .bck(bck_m), .lrck(lrck_m),
    .datl(dl_m), .datr(dr_m), .frame_start(fs_m), .underrun(ur_m),
    .underrun_cnt(cnt_m));

  i2s_frame_controller #(.CLK_DIV(CD), .WIDTH(W), .MUTE_ON_UNDERRUN(0)) u_hold (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(rdy_h),
    .in_left(in_left), .in_right(in_right), .bck(bck_h), .lrck(lrck_h),
    .datl(dl_h), .datr(dr_h), .frame_start(fs_h), .underrun(ur_h),
    .underrun_cnt(cnt_h));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (timeline view) ----------------
  bit          m_run = 0;
  int          m_r = 0;       // clk edges since the enabling edge
  bit          m_full = 0;
  bit          m_acc = 0;
  logic [15:0] m_bl = 0, m_br = 0;
  logic [15:0] m_dlm = 0, m_drm = 0, m_dlh = 0, m_drh = 0;
  int          m_cnt = 0;
  int          m_edges = 0;
  bit          sbq[$];        // expected underrun flag per load point

  initial begin
    bit load, acc;
    forever begin
      @(posedge clk);
      m_edges++;
      m_acc = 0;
      if (reset) begin
        m_run = 0; m_r = 0; m_full = 0; m_cnt = 0;
        m_dlm = 0; m_drm = 0; m_dlh = 0; m_drh = 0;
        sbq.delete();
      end else begin
        load = 0;
        acc  = in_valid && !m_full;
        if (!m_run) begin
          if (en) begin m_run = 1; m_r = 0; end
        end else if (!en) begin
          m_run = 0;
        end else begin
          m_r++;
          load = ((m_r % P) == LOADR);
        end
        if (load) begin
          if (m_full) begin
            m_dlm = m_bl; m_drm = m_br; m_dlh = m_bl; m_drh = m_br;
            m_full = 0;
            sbq.push_back(1'b0);
          end else begin
            if (m_cnt < 255) m_cnt++;
            m_dlm = 0; m_drm = 0;
            sbq.push_back(1'b1);
          end
        end
        if (acc) begin
          m_bl = in_left; m_br = in_right; m_full = 1; m_acc = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int eb, el;
    bit e;
    forever begin
      @(negedge clk);
      if (m_edges > 0) begin
        eb = m_run ? ((m_r / CD) % 2) : 0;
        el = m_run ? ((((m_r / (2 * CD)) % (2 * W)) >= W) ? 1 : 0) : 0;
        check("bck",        bck_m,  eb);
        check("lrck",       lrck_m, el);
        check("bck_hold",   bck_h,  eb);
        check("lrck_hold",  lrck_h, el);
        check("in_ready",   rdy_m,  !m_full);
        check("in_ready_h", rdy_h,  !m_full);
        check("ucnt",       cnt_m,  m_cnt);
        check("ucnt_hold",  cnt_h,  m_cnt);
        check("datl_mute",  dl_m,   m_dlm);
        check("datr_mute",  dr_m,   m_drm);
        check("datl_hold",  dl_h,   m_dlh);
        check("datr_hold",  dr_h,   m_drh);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("frame_start",      fs_m, 1);
          check("frame_start_hold", fs_h, 1);
          check("underrun",         ur_m, e);
          check("underrun_hold",    ur_h, e);
        end else begin
          check("no_frame_start",      fs_m, 0);
          check("no_frame_start_hold", fs_h, 0);
          check("no_underrun",         ur_m, 0);
          check("no_underrun_hold",    ur_h, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_acc();
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (m_acc) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  initial begin
    bit found;
    reset = 1; en = 0; in_valid = 0; in_left = 0; in_right = 0;
    repeat (3) @(negedge clk);

    // first pair in frame 1, then a frame without data
    reset = 0; en = 1;
    in_valid = 1; in_left = 16'h0F0F; in_right = 16'hD52A;
    wait_acc();
    in_valid = 0;
    repeat (2 * P + 10) @(negedge clk);

    // drive the underrun counter well past saturation
    repeat (300 * P) @(negedge clk);

    // valid arriving exactly on a load clk with an empty buffer
    found = 0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      @(negedge clk);
      if (m_run && (m_r % P) == LOADR - 1) found = 1;
    end
    check("load_edge_found", found, 1);
    in_valid = 1; in_left = 16'h1234; in_right = 16'hABCD;
    wait_acc();
    in_valid = 0;
    repeat (P + 10) @(negedge clk);

    // disable mid-frame, re-enable, then reset mid-frame with a pair buffered
    repeat (37) @(negedge clk);
    en = 0;
    repeat (9) @(negedge clk);
    en = 1;
    in_valid = 1; in_left = 16'h5A5A; in_right = 16'hA5A5;
    wait_acc();
    in_valid = 0;
    repeat (50) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (2 * P) @(negedge clk);

    // randomized traffic with occasional disables and resets
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      if (in_valid && m_acc) in_valid = 0;
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        in_valid = 1;
        in_left  = 16'($urandom());
        in_right = 16'($urandom());
      end
      reset = ($urandom_range(0, 4999) == 0);
      if (en && $urandom_range(0, 2999) == 0) en = 0;
      else if (!en && $urandom_range(0, 19) == 0) en = 1;
    end

    in_valid = 0; reset = 0; en = 1;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
